control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cu_pkg.sv | 48 ++++
 rtl/cu_decoder.sv | 30 +++
 rtl/control_unit.sv | 199 +++++++++++++++++++
 tb/tb_control_unit.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: opcode constants, FSM state encoding, ALU op encodings, instruction
// field positions and the decoded-class struct shared by the control unit.
package cu_pkg;

  // Instruction field bit positions
  localparam int OPC_HI  = 19;
  localparam int OPC_LO  = 16;
  localparam int REG_HI  = 15;
  localparam int REG_LO  = 12;
  localparam int ADDR_LO = 0;

  // Opcodes; 8..15 are undefined
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDM  = 4'h1;
  localparam logic [3:0] OP_STM  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_JZ   = 4'h6;
  localparam logic [3:0] OP_HALT = 4'h7;

  // ALU operation encodings
  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // One-hot-ish instruction class; all zero means NOP
  typedef struct packed {
    logic ldm;
    logic stm;
    logic alu;
    logic sub;
    logic jmp;
    logic jz;
    logic halt;
    logic illegal;
  } dec_t;

endpackage

// File: rtl/cu_decoder.sv
// cu_decoder: combinational opcode -> instruction class decode.
// Opcodes 8..15 decode as illegal and carry no other class bit, so the
// sequencer runs them exactly like a NOP.
module cu_decoder
  import cu_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  // Classify the opcode; anything not defined falls through to illegal.
  always_comb begin
    dec = '0;
    case (opcode)
      OP_NOP:  dec = '0;
      OP_LDM:  dec.ldm = 1'b1;
      OP_STM:  dec.stm = 1'b1;
      OP_ADD:  dec.alu = 1'b1;
      OP_SUB:  begin
        dec.alu = 1'b1;
        dec.sub = 1'b1;
      end
      OP_JMP:  dec.jmp = 1'b1;
      OP_JZ:   dec.jz = 1'b1;
      OP_HALT: dec.halt = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/DECODE/EXEC/MEM/WB/HALT sequencer.
// Optional feature macro CU_PERF_COUNT_EN adds a saturating 16-bit instr_cnt
// output counting instructions that return to FETCH.
// Every strobe is a register loaded on the transition into the state that
// owns it, so outputs are glitch-free and purely state-decoded. The
// instruction word is captured on the imem_ready edge; ir_load/pc_inc are
// therefore presented during the single DECODE cycle that follows.
module control_unit
  import cu_pkg::*;
#(
  parameter int INSTR_W = 20,
  parameter int PC_W    = 6,
  parameter int AR_W    = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               imem_ready,
  input  logic               dram_ready,
  input  logic               alu_zero,
  output logic               imem_req,
  output logic               ir_load,
  output logic               pc_inc,
  output logic               pc_load,
  output logic [PC_W-1:0]    pc_target,
  output logic               ar_load,
  output logic [AR_W-1:0]    ar_val,
  output logic               dram_re,
  output logic               dram_we,
  output logic [1:0]         alu_op,
  output logic               rf_we,
  output logic [3:0]         rf_sel,
  output logic               halted,
  output logic               illegal,
  output logic               z_flag
`ifdef CU_PERF_COUNT_EN
  ,output logic [15:0]       instr_cnt
`endif
);

  state_t          state;
  dec_t            dec;
  dec_t            dec_r;
  logic [3:0]      reg_r;
  logic [PC_W-1:0] tgt_r;

  cu_decoder u_dec (
    .opcode (instr[OPC_HI:OPC_LO]),
    .dec    (dec)
  );

  // Sequencer: state, latched instruction fields and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FETCH;
      dec_r     <= '0;
      reg_r     <= 4'h0;
      tgt_r     <= '0;
      imem_req  <= 1'b0;
      ir_load   <= 1'b0;
      pc_inc    <= 1'b0;
      pc_load   <= 1'b0;
      pc_target <= '0;
      ar_load   <= 1'b0;
      ar_val    <= '0;
      dram_re   <= 1'b0;
      dram_we   <= 1'b0;
      alu_op    <= ALU_PASS;
      rf_we     <= 1'b0;
      rf_sel    <= 4'h0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      z_flag    <= 1'b0;
    end else begin
      // Single-cycle strobes default low; states below re-assert as needed.
      ir_load <= 1'b0;
      pc_inc  <= 1'b0;
      pc_load <= 1'b0;
      ar_load <= 1'b0;
      rf_we   <= 1'b0;
      illegal <= 1'b0;
      case (state)
        ST_FETCH: begin
          // A ready is only honoured while our request is actually out.
          if (imem_req && imem_ready) begin
            imem_req <= 1'b0;
            ir_load  <= 1'b1;
            pc_inc   <= 1'b1;
            dec_r    <= dec;
            reg_r    <= instr[REG_HI:REG_LO];
            tgt_r    <= instr[PC_W-1:0];
            if (dec.ldm || dec.stm) begin
              ar_load <= 1'b1;
              ar_val  <= instr[ADDR_LO +: AR_W];
            end
            state <= ST_DECODE;
          end else begin
            imem_req <= 1'b1;
          end
        end
        ST_DECODE: begin
          illegal <= dec_r.illegal;
          if (dec_r.alu) begin
            alu_op <= dec_r.sub ? ALU_SUB : ALU_ADD;
          end else begin
            alu_op <= ALU_PASS;
          end
          if (dec_r.jmp || dec_r.jz) begin
            pc_target <= tgt_r;
          end
          pc_load <= dec_r.jmp | (dec_r.jz & z_flag);
          state   <= ST_EXEC;
        end
        ST_EXEC: begin
          if (dec_r.alu) begin
            rf_we  <= 1'b1;
            rf_sel <= reg_r;
            state  <= ST_WB;
          end else if (dec_r.ldm) begin
            dram_re <= 1'b1;
            state   <= ST_MEM;
          end else if (dec_r.stm) begin
            dram_we <= 1'b1;
            state   <= ST_MEM;
          end else if (dec_r.halt) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else begin
            imem_req <= 1'b1;
            state    <= ST_FETCH;
          end
        end
        ST_MEM: begin
          if (dram_ready) begin
            dram_re <= 1'b0;
            dram_we <= 1'b0;
            if (dec_r.ldm) begin
              rf_we  <= 1'b1;
              rf_sel <= reg_r;
              state  <= ST_WB;
            end else begin
              imem_req <= 1'b1;
              state    <= ST_FETCH;
            end
          end else begin
            state <= ST_MEM;
          end
        end
        ST_WB: begin
          if (dec_r.alu) begin
            z_flag <= alu_zero;
          end
          alu_op   <= ALU_PASS;
          imem_req <= 1'b1;
          state    <= ST_FETCH;
        end
        ST_HALT: begin
          halted <= 1'b1;
          state  <= ST_HALT;
        end
        default: begin
          imem_req <= 1'b0;
          dram_re  <= 1'b0;
          dram_we  <= 1'b0;
          state    <= ST_FETCH;
        end
      endcase
    end
  end

`ifdef CU_PERF_COUNT_EN
  logic fetch_entry;

  // Flag the cycles whose closing edge returns the FSM to FETCH.
  always_comb begin
    fetch_entry = 1'b0;
    case (state)
      ST_EXEC: fetch_entry = ~(dec_r.alu | dec_r.ldm | dec_r.stm | dec_r.halt);
      ST_MEM:  fetch_entry = dram_ready & dec_r.stm;
      ST_WB:   fetch_entry = 1'b1;
      default: fetch_entry = 1'b0;
    endcase
  end

  // Saturating count of instructions completed back to FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt <= 16'h0000;
    end else if (fetch_entry && (instr_cnt != 16'hFFFF)) begin
      instr_cnt <= instr_cnt + 16'h0001;
    end else begin
      instr_cnt <= instr_cnt;
    end
  end
`else
  // Counter and instr_cnt port are not built.
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scenario tasks drive instructions and memory handshakes,
// push the strobe events they expect onto exp_q, and compare them with the
// events sampled from the DUT every falling edge into obs_q.
`timescale 1ns/1ps
module tb_control_unit;

  localparam int INSTR_W = 20;
  localparam int PC_W    = 6;
  localparam int AR_W    = 12;

  localparam int K_PCINC  = 1;
  localparam int K_ARLOAD = 2;
  localparam int K_PCLOAD = 3;
  localparam int K_ILL    = 4;
  localparam int K_RFWE   = 5;
  localparam int K_DRE    = 6;
  localparam int K_DWE    = 7;
  localparam int K_VIOL   = 8;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [INSTR_W-1:0] instr = '0;
  logic               imem_ready = 1'b0;
  logic               dram_ready = 1'b0;
  logic               alu_zero = 1'b0;
  logic               imem_req, ir_load, pc_inc, pc_load, ar_load;
  logic [PC_W-1:0]    pc_target;
  logic [AR_W-1:0]    ar_val;
  logic               dram_re, dram_we, rf_we, halted, illegal, z_flag;
  logic [1:0]         alu_op;
  logic [3:0]         rf_sel;
`ifdef CU_PERF_COUNT_EN
  logic [15:0]        instr_cnt;
`endif

  ev_t obs_q[$];
  ev_t exp_q[$];
  int  checks = 0;
  int  fails  = 0;
  int  cyc    = 0;
  int  re_len = 0;
  int  we_len = 0;

  control_unit #(.INSTR_W(INSTR_W), .PC_W(PC_W), .AR_W(AR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (instr),
    .imem_ready (imem_ready),
    .dram_ready (dram_ready),
    .alu_zero   (alu_zero),
    .imem_req   (imem_req),
    .ir_load    (ir_load),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .ar_load    (ar_load),
    .ar_val     (ar_val),
    .dram_re    (dram_re),
    .dram_we    (dram_we),
    .alu_op     (alu_op),
    .rf_we      (rf_we),
    .rf_sel     (rf_sel),
    .halted     (halted),
    .illegal    (illegal),
    .z_flag     (z_flag)
`ifdef CU_PERF_COUNT_EN
    ,.instr_cnt (instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge and log the strobe events seen there.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (dram_re === 1'b1) re_len++;
    else if (re_len != 0) begin obs_q.push_back('{K_DRE, re_len, cyc}); re_len = 0; end
    if (dram_we === 1'b1) we_len++;
    else if (we_len != 0) begin obs_q.push_back('{K_DWE, we_len, cyc}); we_len = 0; end
    if (pc_inc === 1'b1)  obs_q.push_back('{K_PCINC, 0, cyc});
    if (ar_load === 1'b1) obs_q.push_back('{K_ARLOAD, int'(ar_val), cyc});
    if (pc_load === 1'b1) obs_q.push_back('{K_PCLOAD, int'(pc_target), cyc});
    if (illegal === 1'b1) obs_q.push_back('{K_ILL, 0, cyc});
    if (rf_we === 1'b1)   obs_q.push_back('{K_RFWE, int'(rf_sel), cyc});
    if ((pc_inc && pc_load) || (dram_re && dram_we)) obs_q.push_back('{K_VIOL, 0, cyc});
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ready = 1'b0; dram_ready = 1'b0; instr = '0;
    tick(); tick();
    rst_n = 1'b1;
    obs_q.delete(); exp_q.delete(); re_len = 0; we_len = 0;
  endtask

  task automatic wait_fetch(output bit ok);
    int n = 0;
    while (imem_req !== 1'b1 && n < 40) begin tick(); n++; end
    ok = (imem_req === 1'b1);
  endtask

  task automatic fetch_instr(input logic [INSTR_W-1:0] w, output bit ok);
    wait_fetch(ok);
    instr = w; imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0; instr = '0;
  endtask

  task automatic mem_respond(input int delay, output bit ok);
    int n = 0;
    while (!(dram_re === 1'b1 || dram_we === 1'b1) && n < 40) begin tick(); n++; end
    ok = (dram_re === 1'b1 || dram_we === 1'b1);
    repeat (delay) tick();
    dram_ready = 1'b1;
    tick();
    dram_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req, ir_load, pc_inc, pc_load, ar_load, dram_re, dram_we, rf_we, illegal, halted, z_flag} !== 11'b0) begin
      fails++; $display("FAIL reset_strobes: got %b, required all zero",
        {imem_req, ir_load, pc_inc, pc_load, ar_load, dram_re, dram_we, rf_we, illegal, halted, z_flag});
    end
    checks++;
    if (pc_target !== 6'h00 || ar_val !== 12'h000 || alu_op !== 2'b00 || rf_sel !== 4'h0) begin
      fails++; $display("FAIL reset_values: pc_target %h ar_val %h alu_op %b rf_sel %h, required 0", pc_target, ar_val, alu_op, rf_sel);
    end
`ifdef CU_PERF_COUNT_EN
    checks++;
    if (instr_cnt !== 16'h0000) begin fails++; $display("FAIL reset_cnt: got %0d, required 0", instr_cnt); end
`endif
    tick(); tick();
    rst_n = 1'b1;
    checks++;
    if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_idle: imem_req %b, required 0", imem_req); end
    tick();
    checks++;
    if (imem_req !== 1'b1) begin fails++; $display("FAIL reset_first_req: imem_req %b, required 1", imem_req); end
  endtask

  task automatic test_nop_stream();
    int base;
    bit ok;
    do_reset();
    base = cyc;
    instr = 20'h00000; imem_ready = 1'b1; dram_ready = 1'b1;
    for (int k = 0; k < 5; k++) exp_q.push_back('{K_PCINC, 0, base + 2 + 3 * k});
    repeat (15) tick();
    imem_ready = 1'b0; dram_ready = 1'b0;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL nop_events: observed %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].cyc !== exp_q[i].cyc) begin
        fails++; $display("FAIL nop_ev%0d: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
          i, obs_q[i].kind, obs_q[i].cyc - base, exp_q[i].kind, exp_q[i].cyc - base);
      end
    end
    wait_fetch(ok);
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_load_store();
    bit ok1, ok2, ok3, ok4, ok5, ok6;
    obs_q.delete(); exp_q.delete();
    fetch_instr({4'h1, 4'h2, 12'h0A5}, ok1);
    exp_q.push_back('{K_PCINC, 0, 0}); exp_q.push_back('{K_ARLOAD, 'h0A5, 0});
    mem_respond(3, ok2);
    exp_q.push_back('{K_DRE, 4, 0}); exp_q.push_back('{K_RFWE, 2, 0});
    wait_fetch(ok3);
    fetch_instr({4'h2, 4'h5, 12'h123}, ok4);
    exp_q.push_back('{K_PCINC, 0, 0}); exp_q.push_back('{K_ARLOAD, 'h123, 0});
    mem_respond(0, ok5);
    exp_q.push_back('{K_DWE, 1, 0});
    wait_fetch(ok6);
    checks++;
    if (!(ok1 && ok2 && ok3 && ok4 && ok5 && ok6)) begin
      fails++; $display("FAIL ldst_handshake: timeout flags %b, required 111111", {ok1, ok2, ok3, ok4, ok5, ok6});
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL ldst_events: observed %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].val !== exp_q[i].val) begin
        fails++; $display("FAIL ldst_ev%0d: got kind %0d val 'h%0h, required kind %0d val 'h%0h",
          i, obs_q[i].kind, obs_q[i].val, exp_q[i].kind, exp_q[i].val);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_alu_jump();
    bit ok;
    bit all_ok = 1'b1;
    obs_q.delete(); exp_q.delete();
    alu_zero = 1'b0;
    fetch_instr({4'h3, 4'h3, 12'h000}, ok); all_ok &= ok;
    tick();
    checks++;
    if (alu_op !== 2'b01) begin fails++; $display("FAIL add_aluop: got %b, required 01", alu_op); end
    exp_q.push_back('{K_PCINC, 0, 0}); exp_q.push_back('{K_RFWE, 3, 0});
    wait_fetch(ok); all_ok &= ok;
    alu_zero = 1'b1;
    fetch_instr({4'h4, 4'h1, 12'h000}, ok); all_ok &= ok;
    tick();
    checks++;
    if (alu_op !== 2'b10) begin fails++; $display("FAIL sub_aluop: got %b, required 10", alu_op); end
    exp_q.push_back('{K_PCINC, 0, 0}); exp_q.push_back('{K_RFWE, 1, 0});
    wait_fetch(ok); all_ok &= ok;
    checks++;
    if (z_flag !== 1'b1) begin fails++; $display("FAIL zflag_set: got %b, required 1", z_flag); end
    fetch_instr({4'h6, 4'h0, 12'h015}, ok); all_ok &= ok;
    exp_q.push_back('{K_PCINC, 0, 0}); exp_q.push_back('{K_PCLOAD, 'h15, 0});
    wait_fetch(ok); all_ok &= ok;
    alu_zero = 1'b0;
    fetch_instr({4'h4, 4'h1, 12'h000}, ok); all_ok &= ok;
    exp_q.push_back('{K_PCINC, 0, 0}); exp_q.push_back('{K_RFWE, 1, 0});
    wait_fetch(ok); all_ok &= ok;
    checks++;
    if (z_flag !== 1'b0) begin fails++; $display("FAIL zflag_clr: got %b, required 0", z_flag); end
    fetch_instr({4'h6, 4'h0, 12'h015}, ok); all_ok &= ok;
    exp_q.push_back('{K_PCINC, 0, 0});
    wait_fetch(ok); all_ok &= ok;
    fetch_instr({4'h5, 4'h0, 12'h02A}, ok); all_ok &= ok;
    exp_q.push_back('{K_PCINC, 0, 0}); exp_q.push_back('{K_PCLOAD, 'h2A, 0});
    wait_fetch(ok); all_ok &= ok;
    checks++;
    if (!all_ok) begin fails++; $display("FAIL alu_handshake: fetch timeout, required none"); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL alu_events: observed %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].val !== exp_q[i].val) begin
        fails++; $display("FAIL alu_ev%0d: got kind %0d val 'h%0h, required kind %0d val 'h%0h",
          i, obs_q[i].kind, obs_q[i].val, exp_q[i].kind, exp_q[i].val);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_illegal_halt();
    bit ok1, ok2;
    obs_q.delete(); exp_q.delete();
    fetch_instr({4'hC, 4'h7, 12'hFFF}, ok1);
    exp_q.push_back('{K_PCINC, 0, 0}); exp_q.push_back('{K_ILL, 0, 0});
    tick();
    checks++;
    if (illegal !== 1'b1 || {imem_req, ir_load, pc_inc, pc_load, ar_load, dram_re, dram_we, rf_we} !== 8'h00) begin
      fails++; $display("FAIL illegal_exec: illegal %b strobes %b, required 1 and 00000000", illegal,
        {imem_req, ir_load, pc_inc, pc_load, ar_load, dram_re, dram_we, rf_we});
    end
    tick();
    checks++;
    if (illegal !== 1'b0 || imem_req !== 1'b1) begin
      fails++; $display("FAIL illegal_after: illegal %b imem_req %b, required 0 and 1", illegal, imem_req);
    end
    fetch_instr({4'h7, 4'h0, 12'h000}, ok2);
    exp_q.push_back('{K_PCINC, 0, 0});
    imem_ready = 1'b1; instr = 20'h00000;
    tick(); tick();
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (halted !== 1'b1 || {imem_req, ir_load, pc_inc, pc_load, ar_load, dram_re, dram_we, rf_we} !== 8'h00) begin
        fails++; $display("FAIL halt_hold%0d: halted %b strobes %b, required 1 and 00000000", k, halted,
          {imem_req, ir_load, pc_inc, pc_load, ar_load, dram_re, dram_we, rf_we});
      end
      tick();
    end
    imem_ready = 1'b0;
    checks++;
    if (!(ok1 && ok2)) begin fails++; $display("FAIL ill_handshake: timeout flags %b, required 11", {ok1, ok2}); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL ill_events: observed %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].val !== exp_q[i].val) begin
        fails++; $display("FAIL ill_ev%0d: got kind %0d val 'h%0h, required kind %0d val 'h%0h",
          i, obs_q[i].kind, obs_q[i].val, exp_q[i].kind, exp_q[i].val);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_mem();
    bit ok1, ok2, ok3;
    int n = 0;
    do_reset();
    alu_zero = 1'b1;
    fetch_instr({4'h4, 4'h0, 12'h000}, ok1);
    wait_fetch(ok2);
    alu_zero = 1'b0;
    checks++;
    if (z_flag !== 1'b1) begin fails++; $display("FAIL rstmem_zpre: got %b, required 1", z_flag); end
    fetch_instr({4'h2, 4'h0, 12'h033}, ok3);
    while (dram_we !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (!(ok1 && ok2 && ok3) || dram_we !== 1'b1) begin
      fails++; $display("FAIL rstmem_enter: dram_we %b flags %b, required 1 and 111", dram_we, {ok1, ok2, ok3});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dram_we !== 1'b0 || z_flag !== 1'b0 || ar_val !== 12'h000) begin
      fails++; $display("FAIL rstmem_async: dram_we %b z_flag %b ar_val %h, required 0 0 000", dram_we, z_flag, ar_val);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (imem_req !== 1'b1 || z_flag !== 1'b0 || dram_we !== 1'b0) begin
      fails++; $display("FAIL rstmem_restart: imem_req %b z_flag %b dram_we %b, required 1 0 0", imem_req, z_flag, dram_we);
    end
    obs_q.delete(); exp_q.delete(); re_len = 0; we_len = 0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit all_ok = 1'b1;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      fetch_instr(20'h00000, ok); all_ok &= ok;
      exp_q.push_back('{K_PCINC, 0, 0});
    end
    wait_fetch(ok); all_ok &= ok;
    tick(); tick();
    checks++;
    if (!all_ok) begin fails++; $display("FAIL b2b_handshake: fetch timeout, required none"); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL b2b_events: observed %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].val !== exp_q[i].val) begin
        fails++; $display("FAIL b2b_ev%0d: got kind %0d val 'h%0h, required kind %0d val 'h%0h",
          i, obs_q[i].kind, obs_q[i].val, exp_q[i].kind, exp_q[i].val);
      end
    end
`ifdef CU_PERF_COUNT_EN
    checks++;
    if (instr_cnt !== 16'd10) begin fails++; $display("FAIL b2b_cnt: got %0d, required 10", instr_cnt); end
`endif
    obs_q.delete(); exp_q.delete();
  endtask

  // Run every scenario in order and print the summary.
  initial begin
    test_reset();
    test_nop_stream();
    test_load_store();
    test_alu_jump();
    test_illegal_halt();
    test_reset_mid_mem();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
